bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, consecutive denied M1-requesting cycles before M1 is forced a grant; legal range 1..15.
REQ-002 Parameter: MAX_HOLD, default 8, max consecutive M0 grant cycles before M0 may be preempted; legal range 2..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 m0_req_i  input  1  master 0 (CPU data port) bus request.
REQ-006 m0_lock_i  input  1  master 0 atomic lock; suppresses preemption of M0.
REQ-007 m1_req_i  input  1  master 1 (instruction fetch) bus request.
REQ-008 m0_gnt_o  output  1  master 0 owns bus this cycle.
REQ-009 m1_gnt_o  output  1  master 1 owns bus this cycle.
REQ-010 owner_o  output  2  registered owner code: 2'b00 none, 2'b01 M0, 2'b10 M1.
REQ-011 hold_flag_o  output  1  pipeline stall: M1 requesting but not granted.

Function
REQ-012 FSM states IDLE, OWN_M0, OWN_M1; m0_gnt_o = (state==OWN_M0), m1_gnt_o = (state==OWN_M1), owner_o encodes state; grants never both high.
REQ-013 Grant latency: request sampled at edge N gives grant in cycle following edge N; grants are register-driven, no combinational req->gnt path.
REQ-014 hold_flag_o = m1_req_i & ~m1_gnt_o, combinational from inputs and state.
REQ-015 hold_cnt counts consecutive cycles in current owner state; cleared to 0 on every state change and in IDLE; saturates at MAX_HOLD-1.
REQ-016 starve_cnt increments each cycle m1_req_i=1 and state!=OWN_M1; cleared when state==OWN_M1 or m1_req_i=0; saturates at STARVE_LIMIT.
REQ-017 force_m1 = m1_req_i & (starve_cnt==STARVE_LIMIT).
REQ-018 IDLE: force_m1 -> OWN_M1; else m0_req_i -> OWN_M0; else m1_req_i -> OWN_M1; else stay.
REQ-019 OWN_M0, m0_lock_i=1: stay while m0_req_i=1; on m0_req_i=0 go OWN_M1 if m1_req_i else IDLE.
REQ-020 OWN_M0, m0_lock_i=0: go OWN_M1 if m1_req_i & (force_m1 | hold_cnt==MAX_HOLD-1 | ~m0_req_i); else IDLE if ~m0_req_i; else stay.
REQ-021 OWN_M1: go OWN_M0 if m0_req_i (M1 keeps at least one grant cycle); else IDLE if ~m1_req_i; else stay.
REQ-022 Ownership hand-over M0<->M1 is direct, no IDLE bubble cycle.
REQ-023 Simultaneous m0_req_i & m1_req_i from IDLE with starve_cnt<STARVE_LIMIT: M0 wins.
REQ-024 m0_lock_i ignored when state!=OWN_M0; lock asserted with m0_req_i=0 does not retain bus.
REQ-025 Counter widths: starve_cnt $clog2(STARVE_LIMIT+1), hold_cnt $clog2(MAX_HOLD); no wrap-around permitted.

Reset
REQ-026 rst=0 at rising edge: state=IDLE, hold_cnt=0, starve_cnt=0; cycle after: m0_gnt_o=0, m1_gnt_o=0, owner_o=2'b00.
REQ-027 Reset mid-grant (any state) drops grant the cycle after the reset edge; requests during reset ignored; arbitration resumes on first edge with rst=1.
REQ-028 hold_flag_o during reset follows REQ-014 (equals m1_req_i once grants are 0).

Verification
REQ-029 Release rst, m1_req_i=1 only at edge 0 -> m1_gnt_o=1 cycle 1, owner_o=2'b10, hold_flag_o=1 in cycle 0 only.
REQ-030 Both requests held high from IDLE, defaults -> M0 granted cycle 1; M0 cycles 1..4 (starve_cnt reaches 4 at edge 4); M1 granted cycle 5; M0 regranted cycle 6.
REQ-031 STARVE_LIMIT=15, MAX_HOLD=8, m0_req_i steady, m1_req_i raised in cycle 3 of M0 ownership -> preemption to M1 after 8th M0 cycle, no IDLE cycle between.
REQ-032 m0_lock_i=1, m0_req_i=1 for 20 cycles, m1_req_i=1 throughout -> m0_gnt_o=1 all 20 cycles, hold_flag_o=1 all cycles; on m0_req_i=0, m1_gnt_o=1 next cycle.
REQ-033 Assert rst=0 while OWN_M1 with both requests high -> grants 0 cycle after reset edge; rst=1 -> M0 granted one cycle later, starve_cnt restarted from 0.
REQ-034 All scenarios: assertion m0_gnt_o & m1_gnt_o never 1; owner_o consistent with grants every cycle.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: M0 (CPU data) is favoured, M1 (instruction fetch) is
// protected from starvation and may preempt M0 after a bounded hold, unless M0 is locked.
module bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int MAX_HOLD     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req_i,
    input  logic       m0_lock_i,
    input  logic       m1_req_i,
    output logic       m0_gnt_o,
    output logic       m1_gnt_o,
    output logic [1:0] owner_o,
    output logic       hold_flag_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_HOLD - 1);

    // Encoding doubles as the owner code, so owner_o comes straight from the register.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_M0 = 2'b01,
        OWN_M1 = 2'b10
    } state_t;

    state_t          state_reg, state_next;
    logic [HW-1:0]   hold_cnt_reg, hold_cnt_next;
    logic [SW-1:0]   starve_cnt_reg, starve_cnt_next;
    logic            force_m1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            hold_cnt_reg   <= '0;
            starve_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            hold_cnt_reg   <= hold_cnt_next;
            starve_cnt_reg <= starve_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        force_m1   = m1_req_i && (starve_cnt_reg == STARVE_MAX);

        unique case (state_reg)
            IDLE: begin
                if (force_m1)      state_next = OWN_M1;
                else if (m0_req_i) state_next = OWN_M0;
                else if (m1_req_i) state_next = OWN_M1;
            end
            OWN_M0: begin
                if (m0_lock_i) begin
                    // A lock only retains the bus while M0 is still asking for it.
                    if (!m0_req_i) state_next = m1_req_i ? OWN_M1 : IDLE;
                end else if (m1_req_i && (force_m1 || hold_cnt_reg == HOLD_MAX || !m0_req_i)) begin
                    state_next = OWN_M1;
                end else if (!m0_req_i) begin
                    state_next = IDLE;
                end
            end
            OWN_M1: begin
                if (m0_req_i)      state_next = OWN_M0;
                else if (!m1_req_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (state_next != state_reg || state_reg == IDLE) begin
            hold_cnt_next = '0;
        end else if (hold_cnt_reg != HOLD_MAX) begin
            hold_cnt_next = hold_cnt_reg + HW'(1);
        end
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!m1_req_i || state_reg == OWN_M1) begin
            starve_cnt_next = '0;
        end else if (starve_cnt_reg != STARVE_MAX) begin
            starve_cnt_next = starve_cnt_reg + SW'(1);
        end
    end

    assign m0_gnt_o    = (state_reg == OWN_M0);
    assign m1_gnt_o    = (state_reg == OWN_M1);
    assign owner_o     = state_reg;
    assign hold_flag_o = m1_req_i & ~m1_gnt_o;

endmodule
